// File: rtl/axil_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : axil_arbiter_2x1
// Purpose  : Two-master / one-slave AXI-Lite arbiter. Read and write paths
//            are arbitrated independently, each with round-robin grant and a
//            single outstanding transaction. The granted requester's payload
//            is forwarded combinationally. Handshakes are gated per channel,
//            so each of AW, W, B (and AR, R) completes exactly once.
// Ports    : clk, rst (synchronous, active-low)
//            s0_*/s1_* : requester-side AW/W/B/AR/R channels
//            m_*       : shared channels toward the downstream slave
// Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter_2x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_awaddr,
  input  logic [2:0]            s0_awprot,
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic [STRB_WIDTH-1:0] s0_wstrb,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  output logic [1:0]            s0_bresp,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [2:0]            s0_arprot,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_awaddr,
  input  logic [2:0]            s1_awprot,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic [STRB_WIDTH-1:0] s1_wstrb,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic [1:0]            s1_bresp,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [2:0]            s1_arprot,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // shared downstream port
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rstate_t;

  // write path state
  wstate_t r_wstate;
  logic    r_wg;        // write grant: 0 = s0, 1 = s1
  logic    r_w_last;    // last requester served on the write path
  logic    r_aw_done;
  logic    r_w_done;

  // read path state
  rstate_t r_rstate;
  logic    r_rg;
  logic    r_r_last;
  logic    r_ar_done;

  // --------------------------------------------------------------------------
  // Write path routing
  // --------------------------------------------------------------------------
  logic w_wg0, w_wg1;
  logic w_awvalid_sel, w_wvalid_sel, w_bready_sel;
  logic w_wboth;
  logic w_aw_hs, w_w_hs, w_b_hs;
  logic w_wpend0, w_wpend1, w_wpick;

  // Everything is qualified by BUSY so that outputs are all-zero in IDLE,
  // including right after reset.
  assign w_wg0 = (r_wstate == W_BUSY) & ~r_wg;
  assign w_wg1 = (r_wstate == W_BUSY) &  r_wg;

  assign w_awvalid_sel = (w_wg0 & s0_awvalid) | (w_wg1 & s1_awvalid);
  assign w_wvalid_sel  = (w_wg0 & s0_wvalid)  | (w_wg1 & s1_wvalid);
  assign w_bready_sel  = (w_wg0 & s0_bready)  | (w_wg1 & s1_bready);
  assign w_wboth       = r_aw_done & r_w_done;

  assign m_awaddr  = w_wg1 ? s1_awaddr : (w_wg0 ? s0_awaddr : {ADDR_WIDTH{1'b0}});
  assign m_awprot  = w_wg1 ? s1_awprot : (w_wg0 ? s0_awprot : 3'b000);
  assign m_awvalid = w_awvalid_sel & ~r_aw_done;
  assign s0_awready = w_wg0 & m_awready & ~r_aw_done;
  assign s1_awready = w_wg1 & m_awready & ~r_aw_done;

  assign m_wdata  = w_wg1 ? s1_wdata : (w_wg0 ? s0_wdata : {DATA_WIDTH{1'b0}});
  assign m_wstrb  = w_wg1 ? s1_wstrb : (w_wg0 ? s0_wstrb : {STRB_WIDTH{1'b0}});
  assign m_wvalid = w_wvalid_sel & ~r_w_done;
  assign s0_wready = w_wg0 & m_wready & ~r_w_done;
  assign s1_wready = w_wg1 & m_wready & ~r_w_done;

  // The response is only accepted once both AW and W have gone through; the
  // requester-side bvalid is qualified the same way so that what it sees as
  // a handshake is always the downstream handshake.
  assign m_bready  = w_bready_sel & w_wboth;
  assign s0_bvalid = w_wg0 & w_wboth & m_bvalid;
  assign s1_bvalid = w_wg1 & w_wboth & m_bvalid;
  assign s0_bresp  = w_wg0 ? m_bresp : 2'b00;
  assign s1_bresp  = w_wg1 ? m_bresp : 2'b00;

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_b_hs  = m_bvalid & m_bready;

  // A write is pending as soon as either of its address or data shows up.
  assign w_wpend0 = s0_awvalid | s0_wvalid;
  assign w_wpend1 = s1_awvalid | s1_wvalid;
  assign w_wpick  = (w_wpend0 & w_wpend1) ? ~r_w_last : w_wpend1;

  // --------------------------------------------------------------------------
  // Read path routing
  // --------------------------------------------------------------------------
  logic w_rg0, w_rg1;
  logic w_arvalid_sel, w_rready_sel;
  logic w_ar_hs, w_r_hs;
  logic w_rpick;

  assign w_rg0 = (r_rstate == R_BUSY) & ~r_rg;
  assign w_rg1 = (r_rstate == R_BUSY) &  r_rg;

  assign w_arvalid_sel = (w_rg0 & s0_arvalid) | (w_rg1 & s1_arvalid);
  assign w_rready_sel  = (w_rg0 & s0_rready)  | (w_rg1 & s1_rready);

  assign m_araddr  = w_rg1 ? s1_araddr : (w_rg0 ? s0_araddr : {ADDR_WIDTH{1'b0}});
  assign m_arprot  = w_rg1 ? s1_arprot : (w_rg0 ? s0_arprot : 3'b000);
  assign m_arvalid = w_arvalid_sel & ~r_ar_done;
  assign s0_arready = w_rg0 & m_arready & ~r_ar_done;
  assign s1_arready = w_rg1 & m_arready & ~r_ar_done;

  assign m_rready  = w_rready_sel & r_ar_done;
  assign s0_rvalid = w_rg0 & r_ar_done & m_rvalid;
  assign s1_rvalid = w_rg1 & r_ar_done & m_rvalid;
  assign s0_rdata  = w_rg0 ? m_rdata : {DATA_WIDTH{1'b0}};
  assign s1_rdata  = w_rg1 ? m_rdata : {DATA_WIDTH{1'b0}};
  assign s0_rresp  = w_rg0 ? m_rresp : 2'b00;
  assign s1_rresp  = w_rg1 ? m_rresp : 2'b00;

  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid & m_rready;

  assign w_rpick = (s0_arvalid & s1_arvalid) ? ~r_r_last : s1_arvalid;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_wg      <= 1'b0;
      r_w_last  <= 1'b1;   // s0 wins the first tie
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          // Grant cycle: nothing is forwarded until the next cycle.
          if (w_wpend0 | w_wpend1) begin
            r_wstate  <= W_BUSY;
            r_wg      <= w_wpick;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        W_BUSY: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if (w_b_hs) begin
            r_w_last <= r_wg;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_rg      <= 1'b0;
      r_r_last  <= 1'b1;
      r_ar_done <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s0_arvalid | s1_arvalid) begin
            r_rstate  <= R_BUSY;
            r_rg      <= w_rpick;
            r_ar_done <= 1'b0;
          end
        end
        R_BUSY: begin
          if (w_ar_hs) r_ar_done <= 1'b1;
          if (w_r_hs) begin
            r_r_last <= r_rg;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_2x1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axil_arbiter_2x1
// Purpose  : Self-checking bench for axil_arbiter_2x1. Requester tasks drive
//            the s0/s1 ports, a simple slave model answers on the m port,
//            and expected payloads/responses are queued when stimulus is
//            issued and compared when the handshakes happen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter_2x1;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // requester-side inputs (index 0 = s0, 1 = s1)
  logic [1:0][AW-1:0] s_awaddr  = '0;
  logic [1:0][2:0]    s_awprot  = '0;
  logic [1:0]         s_awvalid = '0;
  logic [1:0][DW-1:0] s_wdata   = '0;
  logic [1:0][SW-1:0] s_wstrb   = '0;
  logic [1:0]         s_wvalid  = '0;
  logic [1:0]         s_bready  = '0;
  logic [1:0][AW-1:0] s_araddr  = '0;
  logic [1:0][2:0]    s_arprot  = '0;
  logic [1:0]         s_arvalid = '0;
  logic [1:0]         s_rready  = '0;
  // requester-side outputs
  wire  [1:0]         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  wire  [1:0][1:0]    s_bresp, s_rresp;
  wire  [1:0][DW-1:0] s_rdata;
  // shared side
  wire  [AW-1:0] m_awaddr, m_araddr;
  wire  [2:0]    m_awprot, m_arprot;
  wire           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  wire  [DW-1:0] m_wdata;
  wire  [SW-1:0] m_wstrb;
  logic          m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [1:0]    m_bresp, m_rresp;
  logic [DW-1:0] m_rdata;

  axil_arbiter_2x1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard queues
  logic [63:0] exp_aw[$];   // {prot, addr} in expected grant order
  logic [63:0] exp_w[$];    // {strb, data}
  logic [63:0] exp_ar[$];   // {prot, addr}
  logic [63:0] exp_b0[$], exp_b1[$];
  logic [63:0] exp_r0[$], exp_r1[$];

  // slave model knobs
  logic [1:0] slv_bresp = 2'b00;
  int         bhold     = 1;
  bit         quiet0    = 1'b0;   // s0 must see no read data

  function automatic logic [2:0] prot_of(input bit id);
    return id ? 3'b101 : 3'b001;
  endfunction

  function automatic logic [DW-1:0] rdf(input logic [AW-1:0] a);
    return 32'h12345678 ^ {a, a} ^ 32'h00040004;
  endfunction

  function automatic logic [1:0] rresp_of(input logic [AW-1:0] a);
    return a[3] ? 2'b10 : 2'b00;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: counts m-side handshakes, checks payloads against the queues
  // --------------------------------------------------------------------------
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [AW-1:0] ar_log[64];

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      end else begin
        if (m_awvalid && m_awready) begin
          if (exp_aw.size() == 0) check_eq("aw_unexpected", 64'(m_awaddr), 64'hFFFF_FFFF);
          else begin e = exp_aw.pop_front(); check_eq("m_aw", 64'({m_awprot, m_awaddr}), e); end
          aw_hs++;
        end
        if (m_wvalid && m_wready) begin
          if (exp_w.size() == 0) check_eq("w_unexpected", 64'(m_wdata), 64'hFFFF_FFFF);
          else begin e = exp_w.pop_front(); check_eq("m_w", 64'({m_wstrb, m_wdata}), e); end
          w_hs++;
        end
        if (m_bvalid && m_bready) b_hs++;
        if (m_arvalid && m_arready) begin
          if (exp_ar.size() == 0) check_eq("ar_unexpected", 64'(m_araddr), 64'hFFFF_FFFF);
          else begin e = exp_ar.pop_front(); check_eq("m_ar", 64'({m_arprot, m_araddr}), e); end
          ar_log[ar_hs[5:0]] = m_araddr;
          ar_hs++;
        end
        if (m_rvalid && m_rready) r_hs++;
        if (s_bvalid[0] && s_bready[0]) begin
          if (exp_b0.size() == 0) check_eq("b0_unexpected", 64'(s_bresp[0]), 64'hF);
          else check_eq("s0_bresp", 64'(s_bresp[0]), exp_b0.pop_front());
        end
        if (s_bvalid[1] && s_bready[1]) begin
          if (exp_b1.size() == 0) check_eq("b1_unexpected", 64'(s_bresp[1]), 64'hF);
          else check_eq("s1_bresp", 64'(s_bresp[1]), exp_b1.pop_front());
        end
        if (s_rvalid[0] && s_rready[0]) begin
          if (exp_r0.size() == 0) check_eq("r0_unexpected", 64'(s_rdata[0]), 64'hFFFF_FFFF);
          else check_eq("s0_r", 64'({s_rresp[0], s_rdata[0]}), exp_r0.pop_front());
        end
        if (s_rvalid[1] && s_rready[1]) begin
          if (exp_r1.size() == 0) check_eq("r1_unexpected", 64'(s_rdata[1]), 64'hFFFF_FFFF);
          else check_eq("s1_r", 64'({s_rresp[1], s_rdata[1]}), exp_r1.pop_front());
        end
        check_eq("two_rvalid", 64'(s_rvalid[0] & s_rvalid[1]), 64'h0);
        check_eq("awready_excl", 64'(s_awready[0] & s_awready[1]), 64'h0);
        check_eq("wready_excl", 64'(s_wready[0] & s_wready[1]), 64'h0);
        if (quiet0) check_eq("s0_read_quiet", 64'({s_rvalid[0], s_rresp[0], s_rdata[0]}), 64'h0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slave model on the m port: always ready for AW/W/AR, answers B once both
  // AW and W arrived, answers R per accepted AR.
  // --------------------------------------------------------------------------
  int b_issued = 0, r_issued = 0, bcyc = 0;

  initial begin
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        b_issued = 0; r_issued = 0; bcyc = 0;
      end else begin
        if (m_bvalid) begin
          if (b_hs >= b_issued && bcyc >= bhold) m_bvalid = 1'b0;
          else bcyc++;
        end else if (aw_hs > b_issued && w_hs > b_issued) begin
          m_bvalid = 1'b1; m_bresp = slv_bresp; b_issued++; bcyc = 1;
        end
        if (m_rvalid) begin
          if (r_hs >= r_issued) m_rvalid = 1'b0;
        end else if (ar_hs > r_issued) begin
          m_rvalid = 1'b1;
          m_rdata  = rdf(ar_log[r_issued[5:0]]);
          m_rresp  = rresp_of(ar_log[r_issued[5:0]]);
          r_issued++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Requester tasks (start and end just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic wr(input bit id, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic [SW-1:0] strb, input int lead);
    int cyc = 0;
    bit awd = 0, wd = 0, bd = 0;
    logic ah, wh, bh;
    s_awaddr[id] = addr; s_awprot[id] = prot_of(id);
    s_wdata[id] = data; s_wstrb[id] = strb;
    s_wvalid[id] = 1'b1; s_bready[id] = 1'b1;
    while (!bd && cyc < 200) begin
      if (!awd && cyc >= lead) s_awvalid[id] = 1'b1;
      @(negedge clk);
      ah = s_awvalid[id] & s_awready[id];
      wh = s_wvalid[id] & s_wready[id];
      bh = s_bvalid[id] & s_bready[id];
      @(posedge clk); #1;
      if (ah) begin awd = 1; s_awvalid[id] = 1'b0; end
      if (wh) begin wd = 1; s_wvalid[id] = 1'b0; end
      if (bh) begin bd = 1; s_bready[id] = 1'b0; end
      cyc++;
    end
    check_eq("wr_done_in_time", 64'({awd, wd, bd}), 64'h7);
  endtask

  task automatic rd(input bit id, input logic [AW-1:0] addr);
    int cyc = 0;
    bit ard = 0, rdn = 0;
    logic ah, rh;
    s_araddr[id] = addr; s_arprot[id] = prot_of(id);
    s_arvalid[id] = 1'b1; s_rready[id] = 1'b1;
    while (!rdn && cyc < 200) begin
      @(negedge clk);
      ah = s_arvalid[id] & s_arready[id];
      rh = s_rvalid[id] & s_rready[id];
      @(posedge clk); #1;
      if (ah) begin ard = 1; s_arvalid[id] = 1'b0; end
      if (rh) begin rdn = 1; s_rready[id] = 1'b0; end
      cyc++;
    end
    check_eq("rd_done_in_time", 64'({ard, rdn}), 64'h3);
  endtask

  task automatic push_wr(input bit id, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb);
    exp_aw.push_back(64'({prot_of(id), addr}));
    exp_w.push_back(64'({strb, data}));
    if (id) exp_b1.push_back(64'(slv_bresp));
    else    exp_b0.push_back(64'(slv_bresp));
  endtask

  task automatic push_rd(input bit id, input logic [AW-1:0] addr);
    exp_ar.push_back(64'({prot_of(id), addr}));
    if (id) exp_r1.push_back(64'({rresp_of(addr), rdf(addr)}));
    else    exp_r0.push_back(64'({rresp_of(addr), rdf(addr)}));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs_zero",
             64'(|{m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
                   m_araddr, m_arprot, m_arvalid, m_rready, s_awready, s_wready, s_bvalid,
                   s_bresp, s_arready, s_rvalid, s_rdata, s_rresp}), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int base_aw, base_w, base_b;
    bit seen;

    do_reset();

    // 1: single s0 write, one-cycle arbitration latency
    slv_bresp = 2'b00;
    push_wr(0, 16'h0010, 32'hDEADBEEF, 4'hF);
    fork
      wr(0, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
      begin
        @(negedge clk);
        check_eq("t1_grant_cycle_quiet", 64'({m_awvalid, m_wvalid}), 64'h0);
        @(negedge clk);
        check_eq("t1_forwarded", 64'({m_awvalid, m_wvalid}), 64'h3);
        check_eq("t1_s1_no_ready", 64'({s_awready[1], s_wready[1], s_bvalid[1]}), 64'h0);
      end
    join

    // 2: simultaneous writes, round-robin from a fresh reset
    do_reset();
    push_wr(0, 16'h0100, 32'h0000_0100, 4'hF);
    push_wr(1, 16'h0200, 32'h0000_0200, 4'h3);
    fork
      wr(0, 16'h0100, 32'h0000_0100, 4'hF, 0);
      wr(1, 16'h0200, 32'h0000_0200, 4'h3, 0);
    join
    push_wr(0, 16'h0300, 32'h0000_0300, 4'h1);
    push_wr(1, 16'h0400, 32'h0000_0400, 4'h8);
    fork
      wr(0, 16'h0300, 32'h0000_0300, 4'h1, 0);
      wr(1, 16'h0400, 32'h0000_0400, 4'h8, 0);
    join

    // 3: W two cycles ahead of AW, B held three cycles
    repeat (2) @(posedge clk);
    #1;
    slv_bresp = 2'b10; bhold = 3;
    base_aw = aw_hs; base_w = w_hs; base_b = b_hs;
    push_wr(0, 16'h0030, 32'hCAFE_F00D, 4'h6);
    wr(0, 16'h0030, 32'hCAFE_F00D, 4'h6, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("t3_one_each", 64'({8'(aw_hs - base_aw), 8'(w_hs - base_w), 8'(b_hs - base_b)}),
             64'h010101);
    check_eq("t3_back_idle", 64'({m_awvalid, m_wvalid, m_bready, s_bvalid}), 64'h0);
    @(posedge clk); #1;
    bhold = 1; slv_bresp = 2'b01;

    // 4: s1 read concurrent with s0 write
    quiet0 = 1'b1;
    push_wr(0, 16'h0008, 32'h0BAD_CAFE, 4'hF);
    push_rd(1, 16'h0004);
    fork
      wr(0, 16'h0008, 32'h0BAD_CAFE, 4'hF, 0);
      rd(1, 16'h0004);
    join
    quiet0 = 1'b0;

    // 5: back-to-back reads from both requesters must alternate s0,s1,...
    for (int i = 0; i < 4; i++) begin
      push_rd(0, 16'(16'h1000 + 4 * i));
      push_rd(1, 16'(16'h2000 + 4 * i));
    end
    fork
      for (int i = 0; i < 4; i++) rd(0, 16'(16'h1000 + 4 * i));
      for (int j = 0; j < 4; j++) rd(1, 16'(16'h2000 + 4 * j));
    join

    // 6: reset while the write path is busy with AW done and no B yet
    slv_bresp = 2'b00;
    exp_aw.push_back(64'({prot_of(0), 16'h0050}));
    s_awaddr[0] = 16'h0050; s_awprot[0] = prot_of(0); s_awvalid[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = s_awvalid[0] & s_awready[0];
      @(posedge clk); #1;
    end
    s_awvalid[0] = 1'b0;
    check_eq("t6_aw_accepted", 64'(seen), 64'h1);
    @(negedge clk);
    check_eq("t6_busy_no_b", 64'({m_awvalid, m_bready, s_bvalid[0]}), 64'h0);
    @(posedge clk); #1;
    do_reset();
    push_wr(1, 16'h0060, 32'h6060_6060, 4'hC);
    wr(1, 16'h0060, 32'h6060_6060, 4'hC, 0);

    repeat (3) @(posedge clk);
    check_eq("scoreboard_drained",
             64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b0.size() +
                 exp_b1.size() + exp_r0.size() + exp_r1.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
